// File: rtl/i2c_cfg_pkg.sv
// ---------------------------------------------------------------------------
// i2c_cfg_pkg
// Shared types and constants for the camera-config I2C target.
//   state_e          : protocol FSM states
//   DEV_ADDR_DEFAULT : default 7-bit target address (0xBA write / 0xBB read)
//   BYTE_W / CNT_W   : byte width and bit-counter width (counter spans 0..8)
// ---------------------------------------------------------------------------
package i2c_cfg_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [6:0]       DEV_ADDR_DEFAULT = 7'h5D;
  localparam logic [CNT_W-1:0] LAST_BIT         = CNT_W'(7);  // count before the 8th rise
  localparam logic [CNT_W-1:0] FULL_BYTE        = CNT_W'(8);  // all 8 bits clocked

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_cfg_target_if.sv
// ---------------------------------------------------------------------------
// i2c_cfg_target_if
// Bus + register-side signals of the I2C config target.
//   iSCL, iSDA   : I2C pins as seen by the target (iSDA is the wired-AND line)
//   oSDA_OE      : 1 = target pulls SDA low
//   oREG_*       : register write strobe, sub-address, write data
//   iREG_RDATA   : read data for oREG_ADDR
//   oBUSY, oNACK : bus-busy flag, master-NACK pulse
// Modports: slave = the target, master = bus master / register file side.
// ---------------------------------------------------------------------------
interface i2c_cfg_target_if;

  logic                            iSCL;
  logic                            iSDA;
  logic                            oSDA_OE;
  logic                            oREG_WE;
  logic [i2c_cfg_pkg::BYTE_W-1:0]  oREG_ADDR;
  logic [i2c_cfg_pkg::BYTE_W-1:0]  oREG_WDATA;
  logic [i2c_cfg_pkg::BYTE_W-1:0]  iREG_RDATA;
  logic                            oBUSY;
  logic                            oNACK;

  modport slave (
    input  iSCL, iSDA, iREG_RDATA,
    output oSDA_OE, oREG_WE, oREG_ADDR, oREG_WDATA, oBUSY, oNACK
  );

  modport master (
    output iSCL, iSDA, iREG_RDATA,
    input  oSDA_OE, oREG_WE, oREG_ADDR, oREG_WDATA, oBUSY, oNACK
  );

endinterface

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Synchronises the asynchronous SCL/SDA pins into the iCLK domain and
// derives single-cycle bus events.
//   i_clk, i_rst     : system clock, synchronous active-high reset
//   i_scl, i_sda     : raw pins
//   o_sda            : synchronised SDA level (aligned with the events)
//   o_scl_rise/fall  : SCL edge pulses
//   o_start, o_stop  : SDA fall / rise while SCL stays high
// Sync flops reset to 1 (idle bus) so reset never fabricates an event.
// ---------------------------------------------------------------------------
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  // SCL must be high both before and after the SDA edge.
  assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_cfg_target.sv
// ---------------------------------------------------------------------------
// i2c_cfg_target
// I2C target for the camera-config bus. Decodes {dev addr, sub-addr, data...}
// write frames into register write strobes and serves reads from iREG_RDATA
// (sub-address set by a write of the sub-address followed by repeated START).
// Ports:
//   iCLK  : system clock (>= 20x SCL)
//   iRST  : synchronous reset, active-high
//   bus   : i2c_cfg_target_if.slave (pins, register strobes, status)
// Parameters: DEV_ADDR (7-bit address), SYNC_STAGES (>= 2).
// Build option: define AUTO_INCREMENT_EN to advance oREG_ADDR (8-bit wrap)
// after each write strobe and each master-ACKed read byte.
// ---------------------------------------------------------------------------
module i2c_cfg_target
  import i2c_cfg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  i2c_cfg_target_if.slave   bus
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (iCLK),
    .i_rst      (iRST),
    .i_scl      (bus.iSCL),
    .i_sda      (bus.iSDA),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0]   r_shift, w_shift_nxt;
  logic [BYTE_W-1:0]   r_addr, w_addr_nxt;
  logic [BYTE_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_oe, w_oe_nxt;
  logic                r_we, w_we_nxt;
  logic                r_nack, w_nack_nxt;
  logic [BYTE_W-1:0]   w_rx_byte;

  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_nack  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_oe    <= w_oe_nxt;
      r_we    <= w_we_nxt;
      r_nack  <= w_nack_nxt;
    end
  end

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_oe_nxt    = r_oe;
    w_we_nxt    = 1'b0;
    w_nack_nxt  = 1'b0;
    w_rx_byte   = {r_shift[BYTE_W-2:0], w_sda};

`ifdef AUTO_INCREMENT_EN
    // Advance the pointer the cycle after the strobe so the strobe carries
    // the address it was written to.
    if (r_we) w_addr_nxt = r_addr + 8'd1;
`endif

    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
    end else if (w_start) begin
      // Repeated START lands here too; r_addr is kept as the read pointer.
      w_state_nxt = ST_DEV;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_DEV, ST_SUB, ST_WR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BIT) begin
              w_cnt_nxt = '0;
              if (r_state == ST_DEV) begin
                w_state_nxt = (w_rx_byte[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
              end else if (r_state == ST_SUB) begin
                w_addr_nxt  = w_rx_byte;
                w_state_nxt = ST_SUB_ACK;
              end else begin
                w_wdata_nxt = w_rx_byte;
                w_we_nxt    = 1'b1;
                w_state_nxt = ST_WR_ACK;
              end
            end
          end
        end

        // ACK slot: the first SCL fall (8th) pulls SDA, the next (9th) ends it.
        ST_DEV_ACK, ST_SUB_ACK, ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt = 1'b0;
              if (r_state == ST_DEV_ACK && r_shift[0]) begin
                // Read: first data bit goes out on this same falling edge.
                w_state_nxt = ST_RD;
                w_cnt_nxt   = '0;
                w_shift_nxt = bus.iREG_RDATA;
                w_oe_nxt    = ~bus.iREG_RDATA[BYTE_W-1];
              end else if (r_state == ST_DEV_ACK) begin
                w_state_nxt = ST_SUB;
              end else begin
                w_state_nxt = ST_WR;
              end
            end
          end
        end

        ST_RD: begin
          // Shifting on the rise keeps the next outgoing bit in r_shift[7].
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end else if (w_scl_fall) begin
            if (r_cnt == '0) begin
              w_shift_nxt = bus.iREG_RDATA;
              w_oe_nxt    = ~bus.iREG_RDATA[BYTE_W-1];
            end else if (r_cnt == FULL_BYTE) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_RD_ACK;
            end else begin
              w_oe_nxt = ~r_shift[BYTE_W-1];
            end
          end
        end

        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_state_nxt = ST_RD;
              w_cnt_nxt   = '0;
`ifdef AUTO_INCREMENT_EN
              w_addr_nxt  = r_addr + 8'd1;
`endif
            end else begin
              w_nack_nxt  = 1'b1;
              w_state_nxt = ST_IGNORE;
            end
          end
        end

        default: ;  // IDLE / IGNORE wait for START or STOP
      endcase
    end
  end

  assign bus.oSDA_OE    = r_oe;
  assign bus.oREG_WE    = r_we;
  assign bus.oREG_ADDR  = r_addr;
  assign bus.oREG_WDATA = r_wdata;
  assign bus.oBUSY      = (r_state != ST_IDLE);
  assign bus.oNACK      = r_nack;

endmodule

// File: tb/tb_i2c_cfg_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_cfg_target
// Bit-banged I2C master driving i2c_cfg_target through its interface, with a
// register-array read model and an expected-write list computed from the
// frame contents (sub-address plus optional auto-increment).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_cfg_target;

`ifdef AUTO_INCREMENT_EN
  localparam int AUTO_INC = 1;
`else
  localparam int AUTO_INC = 0;
`endif
  localparam int Q = 8;  // iCLK cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;
  int nack_cnt = 0;
  int oe_cnt = 0;
  logic [15:0] obs_q[$];

  always #5 clk = ~clk;

  i2c_cfg_target_if bus_if ();

  assign bus_if.iSDA       = m_sda & ~bus_if.oSDA_OE;
  assign bus_if.iREG_RDATA = mem[bus_if.oREG_ADDR];

  i2c_cfg_target dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus_if)
  );

  always @(posedge clk) begin
    if (bus_if.oREG_WE) obs_q.push_back({bus_if.oREG_ADDR, bus_if.oREG_WDATA});
    if (bus_if.oNACK)   nack_cnt <= nack_cnt + 1;
    if (bus_if.oSDA_OE) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bus master primitives ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1;       wait_q();
    bus_if.iSCL = 1'b1; wait_q();
    m_sda = 1'b0;       wait_q();
    bus_if.iSCL = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;       wait_q();
    bus_if.iSCL = 1'b1; wait_q();
    m_sda = 1'b1;       wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;          wait_q();
    bus_if.iSCL = 1'b1; wait_q();
    s = bus_if.iSDA;    wait_q();
    bus_if.iSCL = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(b[i], s);
      n_vec++;
      if (s !== b[i]) begin
        n_err++;
        $display("FAIL data_line byte=%h bit=%0d got %b want %b", b, i, s, b[i]);
      end
    end
    clock_bit(1'b1, s);
    ack = (s === 1'b0);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  // ---------------- frame-level scenarios ----------------
  task automatic do_write(input logic [7:0] sub, input logic [7:0] data [4], input int len);
    logic ack;
    logic [15:0] exp;
    obs_q.delete();
    bus_start();
    n_vec++;
    if (bus_if.oBUSY !== 1'b1) begin
      n_err++; $display("FAIL busy_after_start got %b want 1", bus_if.oBUSY);
    end
    write_byte(8'hBA, ack);
    n_vec++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL ack_dev got %b want 1", ack); end
    write_byte(sub, ack);
    n_vec++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL ack_sub got %b want 1", ack); end
    for (int k = 0; k < len; k++) begin
      write_byte(data[k], ack);
      n_vec++;
      if (ack !== 1'b1) begin n_err++; $display("FAIL ack_data k=%0d got %b want 1", k, ack); end
    end
    bus_stop();
    wait_q();
    n_vec++;
    if (obs_q.size() != len) begin
      n_err++; $display("FAIL we_count got %0d want %0d", obs_q.size(), len);
    end else begin
      for (int k = 0; k < len; k++) begin
        exp = {sub + 8'(k * AUTO_INC), data[k]};
        n_vec++;
        if (obs_q[k] !== exp) begin
          n_err++; $display("FAIL we_entry k=%0d got %h want %h", k, obs_q[k], exp);
        end
      end
    end
    n_vec++;
    if (bus_if.oBUSY !== 1'b0) begin
      n_err++; $display("FAIL busy_after_stop got %b want 0", bus_if.oBUSY);
    end
  endtask

  task automatic do_read(input logic [7:0] sub, input int len);
    logic ack;
    logic [7:0] d, exp;
    int n0;
    obs_q.delete();
    n0 = nack_cnt;
    bus_start();
    write_byte(8'hBA, ack);
    n_vec++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL rd_ack_dev got %b want 1", ack); end
    write_byte(sub, ack);
    n_vec++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL rd_ack_sub got %b want 1", ack); end
    bus_start();
    write_byte(8'hBB, ack);
    n_vec++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL rd_ack_devr got %b want 1", ack); end
    for (int k = 0; k < len; k++) begin
      read_byte(k < len - 1, d);
      exp = mem[sub + 8'(k * AUTO_INC)];
      n_vec++;
      if (d !== exp) begin
        n_err++; $display("FAIL rd_data sub=%h k=%0d got %h want %h", sub, k, d, exp);
      end
    end
    bus_stop();
    wait_q();
    n_vec++;
    if (nack_cnt - n0 != 1) begin
      n_err++; $display("FAIL nack_pulses got %0d want 1", nack_cnt - n0);
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL rd_no_we got %0d want 0", obs_q.size());
    end
    n_vec++;
    if (bus_if.oBUSY !== 1'b0) begin
      n_err++; $display("FAIL rd_busy_after_stop got %b want 0", bus_if.oBUSY);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({bus_if.oSDA_OE, bus_if.oREG_WE, bus_if.oBUSY, bus_if.oNACK} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s_flags got oe=%b we=%b busy=%b nack=%b want 0000", tag,
               bus_if.oSDA_OE, bus_if.oREG_WE, bus_if.oBUSY, bus_if.oNACK);
    end
    n_vec++;
    if ({bus_if.oREG_ADDR, bus_if.oREG_WDATA} !== 16'h0000) begin
      n_err++;
      $display("FAIL %s_regs got addr=%h wdata=%h want 00/00", tag, bus_if.oREG_ADDR, bus_if.oREG_WDATA);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_single_write();
    logic [7:0] d [4] = '{8'hB0, 8'h00, 8'h00, 8'h00};
    do_write(8'h2B, d, 1);
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int oe0;
    logic [7:0] d [4] = '{8'h44, 8'h00, 8'h00, 8'h00};
    obs_q.delete();
    oe0 = oe_cnt;
    bus_start();
    write_byte(8'h90, ack);
    n_vec++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL bad_dev_ack got %b want 0", ack); end
    write_byte(8'h2B, ack);
    write_byte(8'hB0, ack);
    n_vec++;
    if (ack !== 1'b0) begin n_err++; $display("FAIL ignore_ack got %b want 0", ack); end
    bus_stop();
    wait_q();
    n_vec++;
    if (oe_cnt != oe0) begin n_err++; $display("FAIL ignore_oe_cycles got %0d want 0", oe_cnt - oe0); end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL ignore_we got %0d want 0", obs_q.size()); end
    do_write(8'h3C, d, 1);
  endtask

  task automatic test_burst();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
    do_write(8'h2B, d, 3);
  endtask

  task automatic test_read();
    mem[8'h05] = 8'h88;
    mem[8'h06] = 8'h88;
    do_read(8'h05, 2);
  endtask

  task automatic test_abort();
    logic ack, s;
    logic [7:0] d [4] = '{8'h5A, 8'h00, 8'h00, 8'h00};
    obs_q.delete();
    bus_start();
    write_byte(8'hBA, ack);
    write_byte(8'h2B, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s);
    bus_stop();
    wait_q();
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL abort_we got %0d want 0", obs_q.size()); end
    n_vec++;
    if ({bus_if.oBUSY, bus_if.oSDA_OE} !== 2'b00) begin
      n_err++; $display("FAIL abort_idle got busy=%b oe=%b want 0 0", bus_if.oBUSY, bus_if.oSDA_OE);
    end
    // START in the middle of a data byte restarts address decoding.
    bus_start();
    write_byte(8'hBA, ack);
    write_byte(8'h2B, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'($urandom_range(0, 1)), s);
    obs_q.delete();
    bus_if.iSCL = 1'b0;
    m_sda = 1'b1; wait_q();
    bus_if.iSCL = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    bus_if.iSCL = 1'b0; wait_q();
    write_byte(8'hBA, ack);
    n_vec++;
    if (ack !== 1'b1) begin n_err++; $display("FAIL restart_ack got %b want 1", ack); end
    write_byte(8'h2B, ack);
    write_byte(d[0], ack);
    bus_stop();
    wait_q();
    n_vec++;
    if (obs_q.size() != 1 || obs_q[0] !== 16'h2B5A) begin
      n_err++; $display("FAIL restart_we got n=%0d first=%h want 1 entry 2b5a",
                        obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'h0);
    end
  endtask

  task automatic test_reset_midframe();
    logic s;
    logic [7:0] dev = 8'hBA;
    logic [7:0] d [4] = '{8'h7E, 8'h7F, 8'h00, 8'h00};
    logic [7:0] exp_addr;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(dev[i], s);
    m_sda = 1'b1;
    n_vec++;
    if (bus_if.oSDA_OE !== 1'b1) begin
      n_err++; $display("FAIL dev_ack_oe got %b want 1", bus_if.oSDA_OE);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    do_write(8'hFF, d, 2);
    exp_addr = 8'hFF + 8'(2 * AUTO_INC);
    n_vec++;
    if (bus_if.oREG_ADDR !== exp_addr) begin
      n_err++; $display("FAIL wrap_addr got %h want %h", bus_if.oREG_ADDR, exp_addr);
    end
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [7:0] sub;
    for (int t = 0; t < 8; t++) begin
      sub = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
        do_write(sub, d, $urandom_range(1, 4));
      end else begin
        do_read(sub, $urandom_range(1, 3));
      end
    end
  endtask

  initial begin
    bus_if.iSCL = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single_write();
    test_wrong_addr();
    test_burst();
    test_read();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
